// File: rtl/mem_dump_reader_pkg.sv
// mem_dump_reader_pkg: shared FSM states and word/address constants (CHKSUM exists only with DUMP_CHECKSUM_EN)
package mem_dump_reader_pkg;
    localparam int BYTES_PER_WORD = 4;
    localparam int ADDR_STRIDE = 4;
`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, SEND, CHKSUM, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
`endif
endpackage

// File: rtl/mem_dump_reader_word_byte_serializer.sv
// word_byte_serializer: holds one RAM word and hands its bytes out MSB first
module word_byte_serializer
    import mem_dump_reader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] word_in,
    input  logic        advance,
    output logic [7:0]  byte_out,
    output logic        last
);
    logic [31:0] word;
    logic [1:0]  byte_idx;
    // capture a new word or step to the next byte on each accepted transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
            byte_idx <= '0;
        end else if (load) begin
            word <= word_in;
            byte_idx <= '0;
        end else if (advance) begin
            byte_idx <= byte_idx + 2'd1;
        end
    end
    // byte 0 is the top byte, so the shift is (3 - byte_idx) bytes
    assign byte_out = 8'(word >> {~byte_idx, 3'b000});
    assign last = advance && byte_idx == 2'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: streams RAM words byte-wise to a valid/ready sink; DUMP_CHECKSUM_EN appends an XOR byte
module mem_dump_reader
    import mem_dump_reader_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 12
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [NB_ADDR-1:0] i_base_addr,
    input  logic [NB_ADDR-1:0] i_word_count,
    output logic [NB_ADDR-1:0] o_addr,
    input  logic [NB_DATA-1:0] i_mem_data,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);
    state_t state, state_next;
    logic [NB_ADDR-1:0] addr, words_left;
    logic load, advance, last;
    logic [7:0] ser_byte;
`ifdef DUMP_CHECKSUM_EN
    localparam state_t LAST_NEXT = CHKSUM;
    logic [7:0] checksum;
`else
    localparam state_t LAST_NEXT = DONE;
`endif

    assign load = !i_rst && state == LOAD;
    assign advance = !i_rst && state == SEND && i_tx_ready;
    assign o_addr = addr;

    word_byte_serializer u_ser (
        .clk      (clk),
        .rst      (i_rst),
        .load     (load),
        .word_in  (i_mem_data),
        .advance  (advance),
        .byte_out (ser_byte),
        .last     (last)
    );

    // state, address and word counter registers
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= IDLE;
            addr <= '0;
            words_left <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && i_start && i_word_count != '0) begin
                addr <= i_base_addr & ~NB_ADDR'(3);
                words_left <= i_word_count;
            end else if (last && words_left != NB_ADDR'(1)) begin
                addr <= addr + NB_ADDR'(ADDR_STRIDE);
                words_left <= words_left - NB_ADDR'(1);
            end
        end
    end

`ifdef DUMP_CHECKSUM_EN
    // running XOR of every data byte accepted in the current dump
    always_ff @(posedge clk) begin
        if (i_rst || (state == IDLE && i_start))
            checksum <= '0;
        else if (advance)
            checksum <= checksum ^ ser_byte;
    end
`endif

    // next state and outputs; everything forced quiet while reset is held
    always_comb begin
        state_next = state;
        o_tx_valid = 1'b0;
        o_tx_data = '0;
        o_done = 1'b0;
        o_busy = !i_rst && state != IDLE;
        if (!i_rst) begin
            case (state)
                IDLE: if (i_start) state_next = i_word_count == '0 ? DONE : LOAD;
                LOAD: state_next = SEND;
                SEND: begin
                    o_tx_valid = 1'b1;
                    o_tx_data = ser_byte;
                    if (last) state_next = words_left == NB_ADDR'(1) ? LAST_NEXT : LOAD;
                end
`ifdef DUMP_CHECKSUM_EN
                CHKSUM: begin
                    o_tx_valid = 1'b1;
                    o_tx_data = checksum;
                    if (i_tx_ready) state_next = DONE;
                end
`endif
                DONE: begin
                    o_done = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end
endmodule
